mgmt_gpio_arbiter: RTL

//  Shares the single management GPIO pad (gpio_out_pad / gpio_oeb_pad / gpio_in_pad) between N_REQ

---
 rtl/mgmt_gpio_arbiter_if.sv | 16 +
 rtl/mgmt_gpio_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mgmt_gpio_arbiter_if.sv
// Requester-side bundle for the management GPIO arbiter: per-requester
// request / pad drive lines, the grant vector, and the broadcast signals
// returned to all requesters.
interface mgmt_gpio_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_out;
  logic [N_REQ-1:0] req_oe;
  logic [N_REQ-1:0] grant;
  logic             timeout_irq;
  logic             gpio_in;

  modport master (output req, req_out, req_oe, input grant, timeout_irq, gpio_in);
  modport slave  (input req, req_out, req_oe, output grant, timeout_irq, gpio_in);
endinterface

// File: rtl/mgmt_gpio_arbiter.sv
// Management GPIO pad arbiter. Round-robin (or fixed-priority) ownership of
// the single pad, one tri-state turnaround cycle between owners, and an
// optional hold-time limit that revokes and locks out a hogging requester.
module mgmt_gpio_arbiter #(
  parameter int N_REQ  = 3,
  parameter int HOLD_W = 16
) (
  input  logic              core_clk,
  input  logic              core_rstn,
  mgmt_gpio_arbiter_if.slave bus,
  input  logic [HOLD_W-1:0] cfg_max_hold,
  input  logic              cfg_fixed,
  output logic              gpio_out_pad,
  output logic              gpio_oeb_pad,
  input  logic              gpio_in_pad
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]        state;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     rr;
  logic [IW-1:0]     win_idx;
  logic              win_vld;
  logic [N_REQ-1:0]  lockout;
  logic [N_REQ-1:0]  eligible;
  logic [HOLD_W-1:0] hold_cnt;
  logic              own_req;
  logic              release_evt;
  logic              timeout_evt;
  logic              in_s1;
  int                idx;

  assign eligible = bus.req & ~lockout;
  assign own_req  = bus.req[owner];

  // Voluntary release has priority over the hold limit on the same edge.
  assign release_evt = (state == S_OWN) && !own_req;
  assign timeout_evt = (state == S_OWN) && own_req && (cfg_max_hold != '0) &&
                       (hold_cnt >= cfg_max_hold - HOLD_W'(1));

  // Pick the next owner: lowest index in fixed mode, otherwise first
  // eligible index after the last owner. Reverse scan so the first hit wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    if (cfg_fixed) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          win_vld = 1'b1;
          win_idx = IW'(i);
        end
      end
    end else begin
      for (int k = N_REQ; k >= 1; k--) begin
        idx = int'(rr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (eligible[idx]) begin
          win_vld = 1'b1;
          win_idx = IW'(idx);
        end
      end
    end
  end

  // Ownership FSM: grant, owner, round-robin pointer, hold counter, irq.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state           <= S_IDLE;
      owner           <= '0;
      rr              <= '0;
      hold_cnt        <= '0;
      bus.grant       <= '0;
      bus.timeout_irq <= 1'b0;
    end else begin
      bus.timeout_irq <= 1'b0;
      case (state)
        S_IDLE, S_GAP: begin
          hold_cnt <= '0;
          if (win_vld) begin
            bus.grant <= N_REQ'(1) << win_idx;
            owner     <= win_idx;
            state     <= S_OWN;
          end else begin
            bus.grant <= '0;
            state     <= S_IDLE;
          end
        end
        S_OWN: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + HOLD_W'(1);
          if (release_evt) begin
            bus.grant <= '0;
            rr        <= owner;
            state     <= S_GAP;
          end else if (timeout_evt) begin
            bus.grant       <= '0;
            rr              <= owner;
            bus.timeout_irq <= 1'b1;
            state           <= S_GAP;
          end
        end
        default: begin
          bus.grant <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Per-requester lockout: set on hold-limit revoke, cleared whenever req drops.
  for (genvar g = 0; g < N_REQ; g++) begin : g_lock
    logic lock_q;
    always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn)                           lock_q <= 1'b0;
      else if (!bus.req[g])                     lock_q <= 1'b0;
      else if (timeout_evt && owner == IW'(g))  lock_q <= 1'b1;
    end
    assign lockout[g] = lock_q;
  end

  // Pad register: mirror the owner while in OWN, otherwise tri-state and
  // keep the last output value.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      gpio_out_pad <= 1'b0;
      gpio_oeb_pad <= 1'b1;
    end else if (state == S_OWN) begin
      gpio_out_pad <= bus.req_out[owner];
      gpio_oeb_pad <= ~bus.req_oe[owner];
    end else begin
      gpio_oeb_pad <= 1'b1;
    end
  end

  // Two-flop synchroniser for the raw pad input.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      in_s1       <= 1'b0;
      bus.gpio_in <= 1'b0;
    end else begin
      in_s1       <= gpio_in_pad;
      bus.gpio_in <= in_s1;
    end
  end

endmodule
